// File: rtl/dout_uart_pkg.sv
// Shared types and framing constants for the dout_uart output stage.
package dout_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS      = 8;
  localparam int STOP_BITS      = 1;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = DATA_BITS * BYTES_PER_WORD;

endpackage

// File: rtl/dout_uart_if.sv
// Core-facing push port and UART-facing status bundle of dout_uart.
interface dout_uart_if #(
  parameter int DEPTH = 16
);
  import dout_uart_pkg::*;

  logic [WORD_BITS-1:0]   din;
  logic                   din_valid;
  logic                   tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  modport master (
    output din, din_valid,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  din, din_valid,
    output tx, busy, fifo_count, overflow
  );

endinterface

// File: rtl/dout_uart_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when a pop
// frees the slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dout_uart.sv
// Buffers 32-bit core output words and sends each as four 8N1 UART frames,
// least-significant byte first, with a sticky flag for words lost to overflow.
module dout_uart
  import dout_uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input logic        clk,
  input logic        reset,
  dout_uart_if.slave bus
);
  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [1:0]      BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  uart_state_t          state_q;
  logic [BW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [1:0]           byte_q;
  logic [WORD_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 overflow_q;

  logic [WORD_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   baud_done;
  logic                   pop;
  logic                   drop;

  assign baud_done = (baud_q == BAUD_LAST);
  // A word is taken from the FIFO either from IDLE or straight out of the
  // last stop bit, so back-to-back words carry no idle gap.
  assign pop  = !fifo_empty &&
                ((state_q == IDLE) ||
                 (state_q == STOP && baud_done && byte_q == BYTE_LAST));
  assign drop = bus.din_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH(WORD_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.din_valid),
    .pop   (pop),
    .din   (bus.din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= fifo_dout;
            byte_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // Drive the bit that becomes shift[0] after this edge.
              tx_q  <= shift_q[1];
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (byte_q != BYTE_LAST) begin
              byte_q  <= byte_q + 2'd1;
              tx_q    <= 1'b0;
              state_q <= START;
            end else if (pop) begin
              shift_q <= fifo_dout;
              byte_q  <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_dout_uart.sv
// Self-checking bench: table-driven single words, multi-word sequences, reset
// and overflow corners, with a UART line decoder feeding a byte scoreboard.
module tb_dout_uart;
  import dout_uart_pkg::*;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = 40 * CPB;
  localparam int NV       = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dout_uart_if #(.DEPTH(DEPTH)) bus ();

  dout_uart #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b [4];
  } vec_t;

  vec_t        vecs [NV];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  exp_q [$];
  int          starts [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    bus.din_valid = v;
    bus.din       = w;
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_timeout", 32'(n < limit), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART decoder: frame starts on the first low sample, bits sampled mid-cell.
  initial begin
    int         bcnt;
    logic [7:0] rx;
    bit         in_frame;
    bcnt = 0; rx = '0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (bus.tx === 1'b0) begin
          in_frame = 1'b1;
          bcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        bcnt++;
        if (bcnt == CPB/2)
          check("start_bit", 32'(bus.tx), 0);
        else if (bcnt >= CPB && bcnt < 9*CPB && (bcnt % CPB) == CPB/2)
          rx = {bus.tx, rx[7:1]};
        else if (bcnt == 9*CPB + CPB/2)
          check("stop_bit", 32'(bus.tx), 1);
        if (bcnt == 10*CPB - 1) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h, expected none", rx);
          end else begin
            $display("rx byte 0x%02h", rx);
            check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          t0;
    logic [31:0] w [6];

    vecs[0].word = 32'h44332211; vecs[0].b = '{8'h11, 8'h22, 8'h33, 8'h44};
    vecs[1].word = 32'hDEADBEEF; vecs[1].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[2].word = 32'h00000000; vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].word = 32'hFFFFFFFF; vecs[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[4].word = 32'h80000001; vecs[4].b = '{8'h01, 8'h00, 8'h00, 8'h80};

    drive(1'b0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_tx", 32'(bus.tx), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.fifo_count), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("quiet_tx", 32'(bus.tx), 1);
      check("quiet_busy", 32'(bus.busy), 0);
      check("quiet_count", 32'(bus.fifo_count), 0);
    end

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[i].b[k]);
      @(posedge clk); #1 drive(1'b1, vecs[i].word);
      @(posedge clk); #1 drive(1'b0, '0);
      check("vec_count_n1", 32'(bus.fifo_count), 1);
      check("vec_tx_n1", 32'(bus.tx), 1);
      check("vec_busy_n1", 32'(bus.busy), 1);
      @(posedge clk); #1;
      check("vec_tx_start_n2", 32'(bus.tx), 0);
      check("vec_count_n2", 32'(bus.fifo_count), 0);
      wait_idle(400, n);
      check("vec_word_cycles", 32'(n), WORD_CYC);
      check("vec_sb_empty", 32'(exp_q.size()), 0);
      repeat (3) @(posedge clk);
      #1;
    end

    starts.delete();
    push_exp(32'hA5A5A5A5);
    push_exp(32'h0000FFFF);
    @(posedge clk); #1 drive(1'b1, 32'hA5A5A5A5);
    @(posedge clk); #1 drive(1'b1, 32'h0000FFFF);
    @(posedge clk); #1 drive(1'b0, '0);
    check("b2b_count", 32'(bus.fifo_count), 1);
    wait_idle(800, n);
    check("b2b_cycles", 32'(n), 2 * WORD_CYC);
    check("b2b_frames", 32'(starts.size()), 8);
    if (starts.size() == 8)
      for (int i = 1; i < 8; i++)
        check("b2b_frame_spacing", 32'(starts[i] - starts[i-1]), 10 * CPB);
    check("b2b_sb_empty", 32'(exp_q.size()), 0);

    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 5; i++) push_exp(w[i]);
    @(posedge clk); #1 drive(1'b1, w[0]);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        check("ovf_count_full", 32'(bus.fifo_count), 4);
        check("ovf_flag_before", 32'(bus.overflow), 0);
      end
      drive(1'b1, w[i]);
    end
    @(posedge clk); #1 drive(1'b0, '0);
    check("ovf_flag_set", 32'(bus.overflow), 1);
    check("ovf_count_after", 32'(bus.fifo_count), 4);
    wait_idle(1500, n);
    check("ovf_cycles", 32'(n), 5 * WORD_CYC - 4);
    check("ovf_sticky", 32'(bus.overflow), 1);
    check("ovf_sb_empty", 32'(exp_q.size()), 0);

    exp_q.push_back(8'h78);
    exp_q.push_back(8'h56);
    @(posedge clk); #1 drive(1'b1, 32'h12345678);
    @(posedge clk); #1 drive(1'b0, '0);
    @(posedge clk); #1;
    repeat (86) @(posedge clk);
    #2;
    check("rstmid_tx_before", 32'(bus.tx), 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_async", 32'(bus.tx), 1);
    check("rstmid_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rstmid_count", 32'(bus.fifo_count), 0);
    check("rstmid_overflow", 32'(bus.overflow), 0);
    check("rstmid_sb_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("rstmid_quiet_tx", 32'(bus.tx), 1);
    end
    check("rstmid_quiet_busy", 32'(bus.busy), 0);

    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 6; i++) push_exp(w[i]);
    @(posedge clk); #1 drive(1'b1, w[0]);
    t0 = cyc;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1 drive(1'b1, w[i]);
    end
    @(posedge clk); #1 drive(1'b0, '0);
    check("popedge_count_full", 32'(bus.fifo_count), 4);
    while (cyc < t0 + 161) begin
      @(posedge clk); #1;
    end
    check("popedge_count_pre", 32'(bus.fifo_count), 4);
    check("popedge_tx_stop", 32'(bus.tx), 1);
    drive(1'b1, w[5]);
    @(posedge clk); #1 drive(1'b0, '0);
    check("popedge_count_post", 32'(bus.fifo_count), 4);
    check("popedge_overflow", 32'(bus.overflow), 0);
    check("popedge_tx_nogap", 32'(bus.tx), 0);
    wait_idle(1500, n);
    check("popedge_cycles", 32'(n), 5 * WORD_CYC);
    check("popedge_sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
